regfile_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the 32×32 register file. Two write-back producers share the register file's single write port: the ALU stage and the load/memory stage. This block arbitrates between them with valid/ready handshakes and drives a registered write command to the register file. It also keeps a pending-write scoreboard so decode can stall on RAW and WAW hazards.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 64 ++++++
 rtl/regfile_wb_sched.sv | 130 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the register-file write-back
//                path: data/address widths, the hard-wired zero register and
//                the write-back requester encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ALU  = 2'd1,
    REQ_MEM  = 2'd2
  } req_e;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Pending-write scoreboard for the register file. One bit per
//                architectural register marks an outstanding producer. Decode
//                probes three registers and gets a combinational stall.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                set_en, set_addr    mark a register as pending (issue)
//                clr_en, clr_addr    retire a pending register (write-back)
//                rs/rt/rd_addr       decode probes
//                stall               any probed register is pending
//  Revision    : 1.0  initial release
// ============================================================================
module wb_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              stall
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;

  // Register 0 never becomes pending: its mask bits are tied low so the
  // stored bit can only ever reset to and stay at zero.
  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_bit
      if (i == 0) begin : g_zero
        assign w_set_mask[i] = 1'b0;
        assign w_clr_mask[i] = 1'b0;
      end else begin : g_reg
        assign w_set_mask[i] = set_en && (set_addr == ADDR_W'(i));
        assign w_clr_mask[i] = clr_en && (clr_addr == ADDR_W'(i));
      end
    end
  endgenerate

  // Set is applied after clear, so a new producer issued on the same edge
  // that retires the old one keeps the register outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  // Gated with rst so decode sees no hazard during the reset cycle itself,
  // before the cleared vector has been loaded.
  assign stall = !rst && (r_pending[rs_addr] | r_pending[rt_addr] | r_pending[rd_addr]);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_sched
//  Description : Write-back scheduler for the 32x32 register file. Arbitrates
//                the ALU and load producers onto the single write port (load
//                has priority, ALU is force-granted after STARVE_MAX denials),
//                registers the write command and tracks pending writes so
//                decode can stall on RAW/WAW hazards.
//  Ports       : clk, rst                       clock, sync active-high reset
//                alu_valid/addr/data, alu_ready ALU write-back handshake
//                mem_valid/addr/data, mem_ready load write-back handshake
//                rf_we, rf_waddr, rf_wdata      registered write command
//                issue_valid, issue_dst         decode issue (sets pending)
//                rs/rt/rd_addr, stall           hazard probes and stall
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              stall
);

  import mips_pkg::*;

  localparam logic [2:0]        C_STARVE_MAX = 3'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] C_REG_ZERO   = ADDR_W'(REG_ZERO);

  req_e              w_winner;
  logic              w_alu_starved;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [DATA_W-1:0] w_grant_data;
  logic              w_grant_we;
  logic [2:0]        r_starve_cnt;

  assign w_alu_starved = (r_starve_cnt == C_STARVE_MAX);

  // Load wins by default; a starved ALU overrides it. Nothing is granted
  // while rst is high so no transfer can be lost across a reset.
  always_comb begin
    w_winner = REQ_NONE;
    if (!rst) begin
      if (alu_valid && (w_alu_starved || !mem_valid)) begin
        w_winner = REQ_ALU;
      end else if (mem_valid) begin
        w_winner = REQ_MEM;
      end
    end
  end

  assign alu_ready = (w_winner == REQ_ALU);
  assign mem_ready = (w_winner == REQ_MEM);

  always_comb begin
    w_grant_addr = mem_addr;
    w_grant_data = mem_data;
    if (w_winner == REQ_ALU) begin
      w_grant_addr = alu_addr;
      w_grant_data = alu_data;
    end
  end

  // A grant to register 0 completes the handshake but produces no write.
  assign w_grant_we = (w_winner != REQ_NONE) && (w_grant_addr != C_REG_ZERO);

  // Write command register: address/data only move on a real write so the
  // register-file port sees stable values between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_grant_we;
      if (w_grant_we) begin
        rf_waddr <= w_grant_addr;
        rf_wdata <= w_grant_data;
      end
    end
  end

  // Counts consecutive cycles the ALU is kept waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if (!alu_valid || alu_ready) begin
      r_starve_cnt <= 3'd0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end

  // The retiring write is the one visible on the port this cycle, so the
  // pending bit drops at the edge that closes it.
  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_valid && (issue_dst != C_REG_ZERO)),
    .set_addr (issue_dst),
    .clr_en   (rf_we),
    .clr_addr (rf_waddr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_addr  (rd_addr),
    .stall    (stall)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_sched
//  Description : Self-checking bench for regfile_wb_sched. Directed scenarios
//                followed by random traffic, all compared cycle by cycle with
//                a behavioural model of the arbiter, write port and
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_sched;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_addr, mem_addr, issue_dst, rs_addr, rt_addr, rd_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rf_we, stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  bit [31:0] m_pend;
  int        m_starve;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_win;      // 0 none, 1 alu, 2 mem for the cycle just checked

  // Observed values of the cycle just checked
  logic s_alu_ready, s_mem_ready, s_stall;

  always #5 clk = ~clk;

  regfile_wb_sched #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .stall       (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_stall(input bit [4:0] a, input bit [4:0] b, input bit [4:0] c);
    return m_pend[a] | m_pend[b] | m_pend[c];
  endfunction

  task automatic model_reset();
    m_pend = '0; m_starve = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_win = 0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_addr = 0; mem_addr = 0; issue_dst = 0;
    alu_data = 0; mem_data = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0;
  endtask

  // Called just after a falling edge with inputs applied: checks this cycle
  // against the model, advances the model across the rising edge, and
  // returns at the next falling edge.
  task automatic run_cycle();
    bit e_stall;
    #1;
    m_win = 0;
    if (!rst) begin
      if (alu_valid && mem_valid) m_win = (m_starve >= STARVE_MAX) ? 1 : 2;
      else if (alu_valid)         m_win = 1;
      else if (mem_valid)         m_win = 2;
    end
    e_stall = !rst && model_stall(rs_addr, rt_addr, rd_addr);
    s_alu_ready = alu_ready;
    s_mem_ready = mem_ready;
    s_stall     = stall;
    chk("alu_ready", 32'(alu_ready), 32'(m_win == 1));
    chk("mem_ready", 32'(mem_ready), 32'(m_win == 2));
    chk("stall",     32'(stall),     32'(e_stall));
    chk("rf_we",     32'(rf_we),     32'(m_we));
    chk("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
    chk("rf_wdata",  rf_wdata,       m_wdata);

    if (rst) begin
      model_reset();
    end else begin
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (issue_valid && issue_dst != 0) m_pend[issue_dst] = 1'b1;
      if (!alu_valid || m_win == 1) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      m_we = 0;
      if (m_win == 1 && alu_addr != 0) begin
        m_we = 1; m_waddr = alu_addr; m_wdata = alu_data;
      end else if (m_win == 2 && mem_addr != 0) begin
        m_we = 1; m_waddr = mem_addr; m_wdata = mem_data;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit alu_hold, mem_hold;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    run_cycle();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    rst = 0;

    // Lone ALU request
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
    run_cycle();
    chk("t1_alu_ready", 32'(s_alu_ready), 32'd1);
    idle_inputs();
    chk("t1_we",    32'(rf_we),    32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd5);
    chk("t1_wdata", rf_wdata,      32'h1234);
    run_cycle();

    // Contention: mem x3, forced alu, mem again
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_addr = 2; alu_data = 32'hA000 + 32'(c);
      mem_valid = 1; mem_addr = 3; mem_data = 32'hB000 + 32'(c);
      run_cycle();
      chk("t2_alu_grant", 32'(s_alu_ready), 32'(c == 3));
      chk("t2_onehot",    32'(s_alu_ready && s_mem_ready), 32'd0);
    end
    idle_inputs();
    run_cycle();
    run_cycle();

    // Issue/stall and release via ALU write-back
    issue_valid = 1; issue_dst = 7; rs_addr = 7;
    run_cycle();
    issue_valid = 0;
    for (int c = 1; c < 7; c++) begin
      if (c == 4) begin alu_valid = 1; alu_addr = 7; alu_data = 32'h77; end
      else alu_valid = 0;
      run_cycle();
      chk("t3_stall", 32'(s_stall), 32'(c != 6));
    end
    idle_inputs();

    // Same-edge set and clear on register 9
    issue_valid = 1; issue_dst = 9;
    run_cycle();
    issue_valid = 0; alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    run_cycle();
    alu_valid = 0; issue_valid = 1; issue_dst = 9;
    chk("t4_we9", 32'(rf_we && rf_waddr == 9), 32'd1);
    run_cycle();
    issue_valid = 0; rs_addr = 9;
    run_cycle();
    chk("t4_stall", 32'(s_stall), 32'd1);
    alu_valid = 1; alu_addr = 9; alu_data = 32'h999; rs_addr = 0;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Write-back to register 0 and issue to register 0
    mem_valid = 1; mem_addr = 0; mem_data = 32'hFFFF;
    issue_valid = 1; issue_dst = 0;
    run_cycle();
    chk("t5_mem_ready", 32'(s_mem_ready), 32'd1);
    idle_inputs();
    chk("t5_no_we", 32'(rf_we), 32'd0);
    run_cycle();
    chk("t5_stall0", 32'(s_stall), 32'd0);

    // Reset right after a grant
    issue_valid = 1; issue_dst = 4;
    run_cycle();
    issue_valid = 0; alu_valid = 1; mem_valid = 1; alu_addr = 3; mem_addr = 6;
    run_cycle();
    run_cycle();
    alu_valid = 0; mem_valid = 0; rst = 1;
    run_cycle();
    rst = 0; rs_addr = 4;
    chk("t6_we", 32'(rf_we), 32'd0);
    run_cycle();
    chk("t6_stall", 32'(s_stall), 32'd0);
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1; mem_valid = 1; alu_addr = 1; mem_addr = 2;
      run_cycle();
      chk("t6_restart", 32'(s_alu_ready), 32'(c == 3));
    end
    idle_inputs();
    run_cycle();

    // Random traffic with producer hold rules and stall-respecting issue
    alu_hold = 0; mem_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_hold) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_addr  = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      issue_valid = 0;
      issue_dst   = 5'($urandom_range(0, 7));
      if (rst || !model_stall(rs_addr, rt_addr, rd_addr))
        issue_valid = ($urandom_range(0, 2) == 0);
      run_cycle();
      alu_hold = alu_valid && (m_win != 1);
      mem_hold = mem_valid && (m_win != 2);
      if (rst) begin alu_hold = 0; mem_hold = 0; end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
